// File: rtl/imem_loader.sv
// Byte-stream program loader for the 16-bit instruction memory; holds the CPU in reset until a program is written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, WR, FIN, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, WR, FIN, DONE, ERR} state_t;
`endif

  state_t      state;
  logic [15:0] len;
  logic [7:0]  hi_byte;
  logic        accept;
  logic [15:0] full_len;
  logic [15:0] next_count;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, INS_HI, INS_LO: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign full_len   = {len[15:8], in_data};
  assign next_count = 16'(word_count) + 16'd1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over both length bytes and every instruction byte, restarted whenever a load begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (state == IDLE || ((state == DONE || state == ERR) && load)) begin
      csum <= '0;
    end else if (accept && state != CHK) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst    <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      len        <= '0;
      hi_byte    <= '0;
    end else begin
      case (state)
        IDLE: state <= LEN_HI;
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len[7:0] <= in_data;
            if (full_len == 16'd0) begin
              state <= FIN;
            end else if (full_len > 16'(MAX_WORDS)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= INS_HI;
            end
          end
        end
        INS_HI: begin
          if (accept) begin
            hi_byte <= in_data;
            state   <= INS_LO;
          end
        end
        INS_LO: begin
          if (accept) begin
            imem_wdata <= {hi_byte, in_data};
            imem_addr  <= word_count[ADDR_W-1:0];
            imem_we    <= 1'b1;
            state      <= WR;
          end
        end
        WR: begin
          imem_we    <= 1'b0;
          word_count <= next_count[ADDR_W:0];
          state      <= (next_count == len) ? FIN : INS_HI;
        end
        FIN: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state <= CHK;
`else
          state   <= DONE;
          cpu_rst <= 1'b0;
          done    <= 1'b1;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (in_data == csum) begin
              state   <= DONE;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        // Only a load pulse leaves the terminal states; the CPU goes back into reset on that edge.
        DONE, ERR: begin
          if (load) begin
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            cpu_rst    <= 1'b1;
            state      <= LEN_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN when it is defined.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [15:0] imem_wdata;
  logic       cpu_rst;
  logic       done;
  logic       err;
  logic [8:0] word_count;

  int checks = 0;
  int failures = 0;
  int wr_n = 0;
  int rdy_viol = 0;
  logic [7:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  logic [7:0]  chk_acc;

  logic [15:0] prog [10] = '{16'h2281, 16'h2142, 16'h2143, 16'h011A, 16'h088C,
                             16'h6003, 16'h4041, 16'h8002, 16'h2003, 16'hA000};

  imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write monitor: logs every imem write strobe and flags in_ready seen high during a write cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n++;
      if (in_ready) rdy_viol++;
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL byte_timeout: byte %h never accepted, in_ready=%b required 1", b, in_ready);
    end
    chk_acc ^= b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_load(input int n, input int first, input bit gaps);
    logic [15:0] len;
    logic [15:0] w;
    logic [7:0]  c;
    len = 16'(n);
    chk_acc = 8'h00;
    applyStimulus(len[15:8], gaps ? int'($urandom_range(1, 3)) : 0);
    applyStimulus(len[7:0],  gaps ? int'($urandom_range(1, 3)) : 0);
    for (int i = 0; i < n; i++) begin
      w = prog[first + i];
      applyStimulus(w[15:8], gaps ? int'($urandom_range(1, 3)) : 0);
      applyStimulus(w[7:0],  gaps ? int'($urandom_range(1, 3)) : 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    c = chk_acc;
    applyStimulus(c, gaps ? int'($urandom_range(1, 3)) : 0);
`else
    c = 8'h00;
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      checks++;
      failures++;
      $display("[TB] FAIL end_timeout: done=%b err=%b required one of them 1", done, err);
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_rst, in_ready, imem_we, done, err} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags: {cpu_rst,in_ready,we,done,err}=%b required 10000",
               {cpu_rst, in_ready, imem_we, done, err});
    end
    checks++;
    if (imem_addr !== 8'h00 || imem_wdata !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_bus: addr=%h wdata=%h required 00 0000", imem_addr, imem_wdata);
    end
    checks++;
    if (word_count !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_count: word_count=%0d required 0", word_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int snap;
    wr_n = 0;
    send_load(10, 0, 1'b0);
    wait_end();
    checks++;
    if (wr_n !== 10) begin
      failures++;
      $display("[TB] FAIL normal_writes: count=%0d required 10", wr_n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== prog[i]) begin
        failures++;
        $display("[TB] FAIL normal_word%0d: addr=%h data=%h required %h %h",
                 i, wr_addr[i], wr_data[i], 8'(i), prog[i]);
      end
    end
    checks++;
    if ({done, err, cpu_rst} !== 3'b100 || word_count !== 9'd10) begin
      failures++;
      $display("[TB] FAIL normal_end: done/err/cpu_rst=%b count=%0d required 100 10",
               {done, err, cpu_rst}, word_count);
    end
    snap = wr_n;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wr_n !== snap || word_count !== 9'd10 || done !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_ignores_bytes: writes=%0d count=%0d done=%b in_ready=%b required %0d 10 1 0",
               wr_n, word_count, done, in_ready, snap);
    end
  endtask

  task automatic test_backpressure();
    pulse_load();
    checks++;
    if ({done, err, cpu_rst} !== 3'b001 || word_count !== 9'd0) begin
      failures++;
      $display("[TB] FAIL restart_state: done/err/cpu_rst=%b count=%0d required 001 0",
               {done, err, cpu_rst}, word_count);
    end
    wr_n = 0;
    rdy_viol = 0;
    send_load(10, 0, 1'b1);
    wait_end();
    checks++;
    if (wr_n !== 10) begin
      failures++;
      $display("[TB] FAIL bp_writes: count=%0d required 10", wr_n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== prog[i]) begin
        failures++;
        $display("[TB] FAIL bp_word%0d: addr=%h data=%h required %h %h",
                 i, wr_addr[i], wr_data[i], 8'(i), prog[i]);
      end
    end
    checks++;
    if (rdy_viol !== 0) begin
      failures++;
      $display("[TB] FAIL bp_ready_in_wr: in_ready high in %0d write cycles required 0", rdy_viol);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 9'd10) begin
      failures++;
      $display("[TB] FAIL bp_end: done=%b count=%0d required 1 10", done, word_count);
    end
  endtask

  task automatic test_len_zero();
    pulse_load();
    wr_n = 0;
    send_load(0, 0, 1'b0);
    wait_end();
    checks++;
    if (wr_n !== 0 || done !== 1'b1 || err !== 1'b0 || word_count !== 9'd0) begin
      failures++;
      $display("[TB] FAIL len_zero: writes=%0d done=%b err=%b count=%0d required 0 1 0 0",
               wr_n, done, err, word_count);
    end
  endtask

  task automatic test_oversize();
    pulse_load();
    wr_n = 0;
    applyStimulus(8'h01, 0);
    applyStimulus(8'h01, 0);
    wait_end();
    checks++;
    if (wr_n !== 0 || {err, done, cpu_rst, in_ready} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL oversize: writes=%0d err/done/cpu_rst/in_ready=%b required 0 1010",
               wr_n, {err, done, cpu_rst, in_ready});
    end
    pulse_load();
    send_load(1, 0, 1'b0);
    wait_end();
    checks++;
    if (wr_n !== 1 || wr_addr[0] !== 8'h00 || wr_data[0] !== 16'h2281) begin
      failures++;
      $display("[TB] FAIL oversize_reload_write: writes=%0d addr=%h data=%h required 1 00 2281",
               wr_n, wr_addr[0], wr_data[0]);
    end
    checks++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL oversize_reload_end: done/err/cpu_rst=%b required 100", {done, err, cpu_rst});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    pulse_load();
    wr_n = 0;
    applyStimulus(8'h00, 0);
    applyStimulus(8'h0A, 0);
    for (int i = 0; i < 3; i++) begin
      w = prog[i];
      applyStimulus(w[15:8], 0);
      applyStimulus(w[7:0], 0);
    end
    @(negedge clk);
    checks++;
    if (wr_n !== 3 || word_count !== 9'd3) begin
      failures++;
      $display("[TB] FAIL mid_progress: writes=%0d count=%0d required 3 3", wr_n, word_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_rst, in_ready, done} !== 3'b100 || word_count !== 9'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset: cpu_rst/in_ready/done=%b count=%0d required 100 0",
               {cpu_rst, in_ready, done}, word_count);
    end
    @(negedge clk);
    rst = 1'b0;
    wr_n = 0;
    send_load(2, 3, 1'b0);
    wait_end();
    checks++;
    if (wr_n !== 2 || wr_addr[0] !== 8'h00 || wr_data[0] !== prog[3] ||
        wr_addr[1] !== 8'h01 || wr_data[1] !== prog[4]) begin
      failures++;
      $display("[TB] FAIL mid_reload: n=%0d %h:%h %h:%h required 2 00:%h 01:%h",
               wr_n, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], prog[3], prog[4]);
    end
    checks++;
    if (done !== 1'b1 || word_count !== 9'd2) begin
      failures++;
      $display("[TB] FAIL mid_reload_end: done=%b count=%0d required 1 2", done, word_count);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_load();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h81, 0);
    applyStimulus(8'hA2, 0);
    wait_end();
    checks++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL csum_good: done/err/cpu_rst=%b required 100", {done, err, cpu_rst});
    end
    pulse_load();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h81, 0);
    applyStimulus(8'hA3, 0);
    wait_end();
    checks++;
    if ({done, err, cpu_rst} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL csum_bad: done/err/cpu_rst=%b required 011", {done, err, cpu_rst});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_len_zero();
    test_oversize();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: writer side of the processor's 16-bit instruction memory, which the Datapath fetch stage reads.
- Holds the CPU in reset while loading. Receives a 16-bit word count, then that many 16-bit instructions, over a valid/ready byte interface.
- Writes the words to imem addresses 0..N-1, then releases the CPU.
- Replaces hierarchical `IR.mem` preloading in benches and is the path for loading on real hardware.

Parameters:
- ADDR_W, 8, imem address width.
- MAX_WORDS, 256, maximum program length in words; must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle pulse; restarts a load from DONE or ERR, ignored in other states.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte.
- imem_we  output  1  imem write strobe, one cycle per word.
- imem_addr  output  ADDR_W  imem write address.
- imem_wdata  output  16  instruction word.
- cpu_rst  output  1  reset to the Datapath/controlpath, active-high.
- done  output  1  load completed successfully (level).
- err  output  1  load failed (level).
- word_count  output  ADDR_W+1  number of words written so far.

Behaviour:
- Reset values (async, while rst=1):
  - state=IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, word_count=0.
- A byte is accepted at a rising edge where in_valid&&in_ready. in_data must be held stable while in_valid=1 and in_ready=0. in_ready is a decode of state.
- Multi-byte fields are MSB first.
- States and transitions:
  - IDLE: in_ready=0. Always moves to LEN_HI on the next edge.
  - LEN_HI: in_ready=1. On accept, latch len[15:8] and go to LEN_LO.
  - LEN_LO: in_ready=1. On accept, latch len[7:0] and check the full length:
    - len==0: go to FIN.
    - len>MAX_WORDS: go to ERR.
    - otherwise: go to INS_HI.
  - INS_HI: in_ready=1. On accept, latch the high byte and go to INS_LO.
  - INS_LO: in_ready=1. On accept, register imem_wdata={hi,in_data}, imem_addr=word_count[ADDR_W-1:0], imem_we=1, and go to WR.
  - WR: in_ready=0. imem_we is high for exactly this one cycle. Leaving WR: imem_we=0 and word_count+=1. If the new word_count==len, go to FIN; else go to INS_HI.
  - FIN: go to CHK if the optional feature is enabled, else to DONE.
  - DONE: cpu_rst=0, done=1, in_ready=0.
  - ERR: cpu_rst=1, err=1, in_ready=0.
- Restart: a load pulse in DONE or ERR clears done, err and word_count, sets cpu_rst=1 on that edge, and goes to LEN_HI.
- cpu_rst is 1 in every state except DONE. It falls on the edge entering DONE; done rises on the same edge.
- Throughput: at most one word per 3 cycles (HI, LO, WR).
- Latency: imem_we is high in the cycle right after the LO byte is accepted.
- in_valid gaps stall the current state indefinitely with no timeout.
- Bytes arriving in DONE, ERR, IDLE or WR are not accepted.
- Reset mid-load: immediate return to IDLE with cpu_rst=1. Partially written imem contents are left as is. The next load restarts at address 0.
- imem_addr never wraps because len<=MAX_WORDS<=2^ADDR_W.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - Running 8-bit XOR of every accepted byte: both length bytes and all instruction bytes. It is cleared on entry to LEN_HI.
  - CHK state: in_ready=1; accepts one checksum byte. Match goes to DONE; mismatch goes to ERR.
  - len==0 also passes through CHK.
- Disabled: no CHK state and no XOR logic; FIN goes directly to DONE.

Test Plan:
- Normal load, no gaps: send 00 0A, then 10 words 0x2281, 0x2142, 0x2143, 0x011A, 0x088C, 0x6003, 0x4041, 0x8002, 0x2003, 0xA000.
  - Required: 10 imem_we pulses, addr 0..9 with matching data.
  - Required: word_count=10, done=1, cpu_rst=0 after the final write; the CPU then executes the program.
- Backpressure: the same stream with in_valid low 1-3 random cycles between bytes.
  - Required: identical write sequence, no lost or duplicated bytes, in_ready=0 during WR.
- Length 0: send 00 00.
  - Required: no imem_we, done=1, word_count=0.
  - With IMEM_LOADER_CHECKSUM_EN, additionally send checksum byte 00.
- Oversize: send 01 01 (257 > MAX_WORDS=256).
  - Required: no writes, err=1, cpu_rst=1, in_ready=0.
  - Then a load pulse followed by 00 01 22 81 gives a write of 0x2281 at addr 0, then done=1.
- Reset mid-load: assert rst after 3 of 10 words are written.
  - Required: immediate cpu_rst=1, in_ready=0, word_count=0.
  - After release, a fresh 2-word load writes addr 0 and 1.
- Checksum (macro on): stream 00 01 22 81 with checksum 0xA2 → done=1. The same stream with checksum 0xA3 → err=1, cpu_rst=1.
